// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types, line constants and parity helper (TX and RX).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    // Narrower words are zero-extended by the caller; extra zeros do not alter the XOR.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : UART transmit framer: start, LSB-first data, optional parity
//            (macro UART_TX_PARITY_EN), stop bit(s); paced by baud_tick_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 baud_tick_i,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int                CNT_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  C_LAST_BIT = CNT_W'(DATA_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= TX_IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                // busy is still high during the tx_done cycle, so no accept there
                busy_d = 1'b0;
                if (!busy_q && tx_start_i) begin
                    shift_d = tx_data_i;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = calc_parity(9'(tx_data_i), 1'(PARITY_ODD));
`endif
                end
            end
            START: begin
                if (baud_tick_i) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick_i) begin
                    if (bit_cnt_q != C_LAST_BIT) begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d       = TX_IDLE_LEVEL;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick_i) begin
                    tx_d       = TX_IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick_i) begin
                    if ((STOP_BITS == 1) || stop_cnt_q) begin
                        tx_d    = TX_IDLE_LEVEL;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = TX_IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_frame;

    parameter int DATA_BITS  = 8;
    parameter int STOP_BITS  = 1;
    parameter int PARITY_ODD = 0;
    localparam int TICK_PER  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_LEN = 1 + DATA_BITS + PBITS + STOP_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 tx_start = 1'b0;
    logic [DATA_BITS-1:0] tx_data = '0;
    logic                 baud_tick = 1'b0;
    logic                 tx, tx_busy, tx_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_BITS  (DATA_BITS),
        .STOP_BITS  (STOP_BITS)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD (PARITY_ODD)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start_i  (tx_start),
        .tx_data_i   (tx_data),
        .baud_tick_i (baud_tick),
        .tx_o        (tx),
        .tx_busy_o   (tx_busy),
        .tx_done_o   (tx_done)
    );

    // free-running baud tick, one clk wide every TICK_PER clks
    int tcnt = 0;
    always @(negedge clk) begin
        if (tcnt == TICK_PER - 1) begin
            tcnt      = 0;
            baud_tick = 1'b1;
        end else begin
            tcnt      = tcnt + 1;
            baud_tick = 1'b0;
        end
    end

    // ---------------- frame-level model ----------------
    bit                   m_bits [0:31];
    int                   m_k;
    bit                   m_active = 1'b0;
    bit                   m_done   = 1'b0;
    bit                   was_busy;
    bit                   new_done;
    bit                   par;
    logic [DATA_BITS-1:0] acc_q [$];
    bit                   line_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_k      = 0;
        end else begin
            was_busy = m_active || m_done;
            new_done = 1'b0;
            if (m_active) begin
                if (baud_tick) begin
                    line_q.push_back(tx);
                    m_k = m_k + 1;
                    if (m_k == FRAME_LEN) begin
                        m_active = 1'b0;
                        new_done = 1'b1;
                    end
                end
            end else if (!was_busy && tx_start) begin
                m_bits[0] = 1'b0;
                par = (PARITY_ODD != 0);
                for (int i = 0; i < DATA_BITS; i++) begin
                    m_bits[1+i] = tx_data[i];
                    par = par ^ tx_data[i];
                end
                if (PBITS == 1) m_bits[1+DATA_BITS] = par;
                for (int s = 0; s < STOP_BITS; s++) m_bits[1+DATA_BITS+PBITS+s] = 1'b1;
                acc_q.push_back(tx_data);
                m_active = 1'b1;
                m_k      = 0;
            end
            m_done = new_done;
        end
    end

    // per-cycle comparison against the model
    bit exp_tx, exp_busy, exp_done;
    always @(negedge clk) begin
        exp_tx   = m_active ? m_bits[m_k] : 1'b1;
        exp_busy = m_active || m_done;
        exp_done = m_done;
        tests = tests + 1;
        if (tx !== exp_tx || tx_busy !== exp_busy || tx_done !== exp_done) begin
            fails = fails + 1;
            $display("FAIL cycle_model t=%0t: tx/busy/done got %b%b%b want %b%b%b",
                     $time, tx, tx_busy, tx_done, exp_tx, exp_busy, exp_done);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (tx_done !== 1'b1 && n < 40 * TICK_PER) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(tx_done), 32'd1);
        @(negedge clk);
        check({name, "_done_width"}, 32'(tx_done), 32'd0);
        check({name, "_busy_fall"}, 32'(tx_busy), 32'd0);
    endtask

    task automatic send(input logic [DATA_BITS-1:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = DATA_BITS'($urandom);
    endtask

    // compare the captured line, frame by frame, against the accepted bytes
    task automatic check_frames(input string name);
        logic [DATA_BITS-1:0] b, got;
        bit ok;
        bit p;
        check({name, "_line_len"}, 32'(line_q.size()), 32'(acc_q.size() * FRAME_LEN));
        while (acc_q.size() > 0 && line_q.size() >= FRAME_LEN) begin
            b  = acc_q.pop_front();
            ok = (line_q.pop_front() == 1'b0);
            p  = (PARITY_ODD != 0);
            for (int i = 0; i < DATA_BITS; i++) begin
                got[i] = line_q.pop_front();
                p = p ^ b[i];
            end
            if (PBITS == 1) ok = ok && (line_q.pop_front() == p);
            for (int s = 0; s < STOP_BITS; s++) ok = ok && (line_q.pop_front() == 1'b1);
            check({name, "_byte"}, 32'(got), 32'(b));
            check({name, "_framing"}, 32'(ok), 32'd1);
        end
        acc_q.delete();
        line_q.delete();
    endtask

    task automatic check_line_lit(input string name, input bit e [$]);
        bit ok;
        ok = (line_q.size() == e.size());
        for (int i = 0; i < e.size() && ok; i++) ok = (line_q[i] == e[i]);
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit e [$];
        int hold;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_busy", 32'(tx_busy), 32'd0);

        // basic frame 0x55: literal line levels, LSB first
        send(8'h55);
        check("accept_latency_tx", 32'(tx), 32'd0);
        check("accept_busy", 32'(tx_busy), 32'd1);
        wait_done("f55");
        e = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        if (PBITS == 1) e.push_back(PARITY_ODD != 0);
        for (int s = 0; s < STOP_BITS; s++) e.push_back(1'b1);
        check_line_lit("f55_line", e);
        check_frames("f55");

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1, odd parity bit is 0
        send(8'h07);
        wait_done("f07");
        check("f07_len", 32'(line_q.size()), 32'(10 + STOP_BITS));
        check("f07_parity", 32'(line_q[9]), (PARITY_ODD != 0) ? 32'd0 : 32'd1);
        check_frames("f07");
`endif

        // back-to-back with tx_start held high
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'hA3;
        wait_done("b2b_a");
        tx_data = 8'h0F;
        check("b2b_not_in_done_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("b2b_accept_tx", 32'(tx), 32'd0);
        check("b2b_accept_busy", 32'(tx_busy), 32'd1);
        tx_start = 1'b0;
        wait_done("b2b_b");
        check("b2b_count", 32'(acc_q.size()), 32'd2);
        check_frames("b2b");

        // request while busy is dropped, not queued
        send(8'h3C);
        repeat (50) @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_start = 1'b0;
        wait_done("rej");
        repeat (200) @(negedge clk);
        check("rej_idle", 32'(tx_busy), 32'd0);
        check("rej_count", 32'(acc_q.size()), 32'd1);
        check_frames("rej");

        // asynchronous reset during data bit 3 (0x96 bit 3 is 0)
        send(8'h96);
        for (int n = 0; n < 20 * TICK_PER && !(m_active && m_k == 4); n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("mid_bit3_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        line_q.delete();
        repeat (300) @(negedge clk);
        send(8'h5A);
        wait_done("post_rst");
        check_frames("post_rst");

        // randomized frames with held starts, data churn and busy requests
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            tx_start = 1'b1;
            tx_data  = DATA_BITS'($urandom);
            hold = $urandom_range(1, 40);
            repeat (hold) begin
                @(negedge clk);
                tx_data = DATA_BITS'($urandom);
            end
            tx_start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 60)) @(negedge clk);
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
            wait_done("rnd");
            check_frames("rnd");
        end

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framing engine. Sits directly downstream of the TX baud-tick generator and consumes its one-cycle baud tick. Accepts a parallel byte from the host, then serializes it onto the tx line as start, data LSB-first, optional parity, and stop bit(s). Returns tx_done to the tick generator so that generator goes idle.

Parameters:
DATA_BITS, 8, data bits per frame; legal values 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
PARITY_ODD, 0, used only when UART_TX_PARITY_EN is defined; 1 = odd parity, 0 = even parity.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tx_start  in  1  request to send; level or pulse; sampled each clk
tx_data  in  DATA_BITS  byte to send; sampled only in the accept cycle
baud_tick  in  1  one-clk pulse from the baud generator, once per bit period
tx  out  1  serial line; idle high
tx_busy  out  1  frame in progress; new requests are refused while high
tx_done  out  1  one-clk pulse at frame end; wired to the baud generator's tx_done

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state IDLE, tx=1, tx_busy=0, tx_done=0, shift register=0, bit counter=0. A partial frame is abandoned. No tx_done is issued.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Accept rule: accept when state==IDLE && tx_busy==0 && tx_start==1.
  - On the accept edge: latch tx_data into the shift register, set tx=0, move to START, set tx_busy=1.
  - Accept latency is 1 clk from the sampled tx_start to tx falling.
- baud_tick ends the current bit. All transitions after START happen only on baud_tick:
  - START → DATA: tx = shift[0], bit_cnt = 0.
  - DATA: shift right. Present the next bit while bit_cnt < DATA_BITS-1, incrementing bit_cnt.
  - After the last data bit: go to PARITY if enabled, otherwise go to STOP with tx=1.
  - PARITY → STOP: tx=1.
  - STOP: count STOP_BITS ticks. On the final tick go to IDLE, keep tx=1, and pulse tx_done=1 for exactly one clk.
- tx_busy stays 1 from the accept edge through the tx_done cycle inclusive. It falls the clk after tx_done.
  - Consequence: tx_start coincident with tx_done is NOT accepted. This guarantees the generator sees tx_done and a new tx_start in different cycles.
- Frame length: 1 + DATA_BITS + P + STOP_BITS bit periods, where P = 1 with parity and 0 without. Each bit period is delimited by baud_tick.
- baud_tick while in IDLE is ignored.
- tx_start while busy is ignored. It is not queued.
- tx_data changes after the accept edge have no effect.
- tx is a registered output with no combinational path from inputs to tx.
- bit_cnt width is $clog2(DATA_BITS).
- STOP counter: 1 bit, only meaningful when STOP_BITS==2.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state is inserted after the data bits.
  - Parity bit = ^data XOR PARITY_ODD, computed on the latched byte at accept.
  - Frame gains one bit period.
- Undefined: PARITY state, parity register and PARITY_ODD logic are absent. DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam TX_IDLE_LEVEL = 1'b1
  - a function calc_parity(data, odd) that the RX side reuses.
- No sub-module. The block is one FSM plus shift register and counters.
- Top-level integration instantiates this block beside the baud generator. tx_start fans out to both, and tx_done feeds back to the generator.

Test Plan:
- Reset check: rst_n low → tx=1, tx_busy=0, tx_done=0. Release with no stimulus for 100 clk → outputs unchanged.
- Basic frame, 8N1, ticks every 16 clk, send 0x55 → tx = 0,1,0,1,0,1,0,1,0 then stop 1. Each level holds one tick period. tx_done pulses once, 1 clk wide, at the stop tick. tx_busy falls the next clk.
- Back-to-back: hold tx_start=1 continuously with 0xA3 then 0x0F → second frame not accepted in the tx_done cycle. It is accepted the clk after tx_busy falls. Decoded bytes are 0xA3, 0x0F.
- Busy rejection: pulse tx_start mid-frame with 0xFF → ignored. The current frame completes unchanged, and no second frame follows.
- Reset mid-frame during DATA bit 3 → tx=1 immediately (asynchronous). No tx_done. The next accepted request sends a clean full frame.
- UART_TX_PARITY_EN defined, PARITY_ODD=0, send 0x07 → parity bit 1, frame length 11 ticks. With PARITY_ODD=1 → parity bit 0. With STOP_BITS=2 → tx high for 2 ticks before tx_done.
